dcache_param: RTL and testbench
===============================

DCACHE_PARAM -- requirements
Module: dcache_param

Interface
REQ-001 The block SHALL take parameter NSETS, default 8, meaning number of sets; power of 2, at least 2.
REQ-002 The block SHALL take parameter BLKWORDS, default 2, meaning 32-bit words per block; power of 2, at least 2.
REQ-003 The block SHALL take parameter CNT_ADDR, default 32'h00003100, meaning the word address that receives the hit statistic at flush.
REQ-004 The block SHALL have the following ports:
- CLK, in, 1, clock.
- nRST, in, 1, reset: asynchronous, active-low.
- dmemREN, in, 1, datapath read request.
- dmemWEN, in, 1, datapath write request.
- dmemaddr, in, 32, datapath byte address.
- dmemstore, in, 32, datapath store data.
- halt, in, 1, datapath halted; start flush.
- dhit, out, 1, request served this cycle.
- dmemload, out, 32, read data.
- flushed, out, 1, flush and statistic write complete.
- dREN, out, 1, memory read.
- dWEN, out, 1, memory write.
- daddr, out, 32, memory word address.
- dstore, out, 32, memory write data.
- dload, in, 32, memory read data.
- dwait, in, 1, memory busy; a word transfers on a cycle with dREN or dWEN high and dwait low.

Function
REQ-005 The cache SHALL be 2-way set-associative, write-back, write-allocate; each way entry holds valid, dirty, tag and BLKWORDS words; each set holds one LRU bit naming the victim way.
REQ-006 dmemaddr SHALL split, MSB to LSB, into tag (32-log2(NSETS)-log2(BLKWORDS)-2 bits), index (log2(NSETS)), block offset (log2(BLKWORDS)) and byte offset (2, ignored).
REQ-007 dhit SHALL be combinational: (dmemREN or dmemWEN) and state IDLE and a valid way tag-matches.
REQ-008 On a read hit, dmemload SHALL equal the addressed word in the same cycle; on a write hit, the word, the dirty bit (set to 1) and the LRU bit SHALL update at the next edge.
REQ-009 On any hit, LRU SHALL be set to the other way.
REQ-010 States SHALL be IDLE, WB, LD, FLUSH_SCAN, FLUSH_WB, CNT_WR and HALT.
REQ-011 On a miss in IDLE, the FSM SHALL go to WB if the LRU way is valid and dirty, else to LD.
REQ-012 WB SHALL write BLKWORDS words from the victim, addresses {victim tag, index, word counter, 2'b00}, with the word counter incrementing on each transfer; after the last word the dirty bit SHALL clear and the FSM SHALL go to LD.
REQ-013 LD SHALL read BLKWORDS words into the victim way in ascending order; valid SHALL be held 0 until the last word lands, at which point valid=1, dirty=0 and tag are written; the FSM then SHALL return to IDLE, where the access hits.
REQ-014 halt in IDLE with no pending request SHALL go to FLUSH_SCAN; a request takes priority over halt.
REQ-015 FLUSH_SCAN SHALL visit (set, way) pairs 0..2*NSETS-1 at one per cycle, entering FLUSH_WB for each valid dirty entry.
REQ-016 FLUSH_WB SHALL write that block as in WB, clear its dirty bit, and return to FLUSH_SCAN at the next pair.
REQ-017 After the last pair the FSM SHALL go to CNT_WR.
REQ-018 hit_cnt (32 bits) SHALL increment on every cycle dhit=1, and miss_cnt (32 bits) on every LD completion; both SHALL wrap modulo 2^32.
REQ-019 CNT_WR SHALL write hit_cnt minus miss_cnt (modulo 2^32) to CNT_ADDR until dwait=0, then go to HALT.
REQ-020 HALT SHALL be terminal, with flushed=1 and no memory requests.
REQ-021 dREN and dWEN SHALL never both be 1, and SHALL be 0 in IDLE, FLUSH_SCAN and HALT.
REQ-022 All state, counters and array updates SHALL be on posedge CLK only; no derived clocks.

Reset
REQ-023 On nRST low, all entries SHALL become valid=0, dirty=0, tag=0, data=0, LRU=0; the FSM SHALL go to IDLE; word, scan and statistic counters SHALL go to 0.
REQ-024 Outputs during reset SHALL be dhit=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0 and dmemload=0.
REQ-025 Reset mid-WB or mid-LD SHALL abandon the transfer with no partial valid line remaining.

Structure
REQ-026 The address-field typedef, its width functions and the state enum SHALL live in cpu_types_pkg.
REQ-027 The block SHALL use one sub-module, dcache_way_array, a per-way storage array with registered write and combinational read.

Verification
REQ-028 Read 0x100 after reset with dwait low in 2 cycles -> LD fetches 0x100 and 0x104, then dhit=1 and dmemload=mem[0x100].
REQ-029 Write 0xDEADBEEF to 0x100 (hit), then read 0x100 -> dhit the same cycle, dmemload=0xDEADBEEF, with no memory traffic.
REQ-030 Dirty 0x100, then miss 0x200 and 0x300 to the same set -> one WB of the 0x100 block before LD of 0x300, with LRU alternating.
REQ-031 halt with 3 dirty blocks -> exactly 3*BLKWORDS writes, then a write of (hits-misses) to 0x3100, then flushed=1 and held.
REQ-032 Assert nRST mid-LD -> the next read of the same address misses and refetches.
REQ-033 Run with NSETS=16 and BLKWORDS=4 -> a 4-word burst on miss and correct index/tag split at addresses 0x0 and 0x3F0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared cache types: address layout, field-width helpers and the controller state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;

    typedef logic [WORD_W-1:0] word_t;

    // Byte address viewed as a word address plus the ignored byte offset.
    typedef struct packed {
        logic [WORD_W-BYTE_OFF_W-1:0] waddr;
        logic [BYTE_OFF_W-1:0]        boff;
    } dcache_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        LD,
        FLUSH_SCAN,
        FLUSH_WB,
        CNT_WR,
        HALT
    } dcache_state_t;

    // Index field width for a given set count.
    function automatic int unsigned idx_w(input int unsigned nsets);
        return $clog2(nsets);
    endfunction

    // Block-offset field width for a given block size in words.
    function automatic int unsigned blk_w(input int unsigned blkwords);
        return $clog2(blkwords);
    endfunction

    // Tag field width: everything above index and block offset.
    function automatic int unsigned tag_w(input int unsigned nsets, input int unsigned blkwords);
        return WORD_W - $clog2(nsets) - $clog2(blkwords) - BYTE_OFF_W;
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: per-set valid/dirty/tag plus block data; registered writes, combinational reads.
module dcache_way_array
    import cpu_types_pkg::*;
#(
    parameter  int unsigned NSETS    = 8,
    parameter  int unsigned BLKWORDS = 2,
    parameter  int unsigned TAGW     = 26,
    localparam int unsigned IW       = idx_w(NSETS),
    localparam int unsigned BW       = blk_w(BLKWORDS)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [IW-1:0]   i_idx,
    input  logic [BW-1:0]   i_off,
    input  logic            i_wen,
    input  logic [31:0]     i_wdata,
    input  logic            i_men,
    input  logic            i_mvalid,
    input  logic            i_mdirty,
    input  logic [TAGW-1:0] i_mtag,
    output logic            o_valid,
    output logic            o_dirty,
    output logic [TAGW-1:0] o_tag,
    output logic [31:0]     o_word
);

    logic            r_valid [NSETS];
    logic            r_dirty [NSETS];
    logic [TAGW-1:0] r_tag   [NSETS];
    word_t           r_data  [NSETS][BLKWORDS];

    // Word and metadata writes; reset clears every entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < int'(NSETS); s++) begin
                r_valid[s] <= 1'b0;
                r_dirty[s] <= 1'b0;
                r_tag[s]   <= '0;
                for (int w = 0; w < int'(BLKWORDS); w++) begin
                    r_data[s][w] <= '0;
                end
            end
        end else begin
            if (i_wen) begin
                r_data[i_idx][i_off] <= i_wdata;
            end
            if (i_men) begin
                r_valid[i_idx] <= i_mvalid;
                r_dirty[i_idx] <= i_mdirty;
                r_tag[i_idx]   <= i_mtag;
            end
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_word  = r_data[i_idx][i_off];

endmodule

// File: rtl/dcache_param.sv
// 2-way set-associative write-back data cache with flush-on-halt and a hit statistic write.
module dcache_param
    import cpu_types_pkg::*;
#(
    parameter int unsigned NSETS    = 8,
    parameter int unsigned BLKWORDS = 2,
    parameter logic [31:0] CNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int unsigned IW = idx_w(NSETS);
    localparam int unsigned BW = blk_w(BLKWORDS);
    localparam int unsigned TW = tag_w(NSETS, BLKWORDS);
    localparam int unsigned SW = IW + 1;

    dcache_state_t r_state, w_next;
    logic [BW-1:0]    r_cnt;
    logic [SW-1:0]    r_scan;
    logic [NSETS-1:0] r_lru;
    word_t            r_hit_cnt, r_miss_cnt;

    dcache_addr_t  w_addr;
    logic [TW-1:0] w_tag;
    logic [IW-1:0] w_idx, w_aidx;
    logic [BW-1:0] w_off, w_aoff;
    logic          w_unused_boff;
    logic          w_flush, w_req, w_hway, w_vway, w_way, w_xfer, w_last;
    logic [1:0]    w_valid, w_dirty, w_match, w_wen, w_men;
    logic [TW-1:0] w_tagr [2];
    word_t         w_word [2];
    logic          w_mvalid, w_mdirty;
    logic [TW-1:0] w_mtag;
    word_t         w_wdata;

    assign w_addr        = dmemaddr;
    assign w_tag         = w_addr.waddr[29 -: TW];
    assign w_idx         = w_addr.waddr[BW +: IW];
    assign w_off         = w_addr.waddr[BW-1:0];
    assign w_unused_boff = ^w_addr.boff;

    // Flush walks (set, way) pairs: upper scan bits select the set, bit 0 the way.
    assign w_flush = (r_state == FLUSH_SCAN) || (r_state == FLUSH_WB);
    assign w_aidx  = w_flush ? r_scan[SW-1:1] : w_idx;
    assign w_aoff  = (r_state == IDLE) ? w_off : r_cnt;

    for (genvar g = 0; g < 2; g++) begin : g_way
        dcache_way_array #(
            .NSETS   (NSETS),
            .BLKWORDS(BLKWORDS),
            .TAGW    (TW)
        ) u_way (
            .CLK     (CLK),
            .nRST    (nRST),
            .i_idx   (w_aidx),
            .i_off   (w_aoff),
            .i_wen   (w_wen[g]),
            .i_wdata (w_wdata),
            .i_men   (w_men[g]),
            .i_mvalid(w_mvalid),
            .i_mdirty(w_mdirty),
            .i_mtag  (w_mtag),
            .o_valid (w_valid[g]),
            .o_dirty (w_dirty[g]),
            .o_tag   (w_tagr[g]),
            .o_word  (w_word[g])
        );
        assign w_match[g] = w_valid[g] && (w_tagr[g] == w_tag);
    end

    assign w_req    = dmemREN | dmemWEN;
    assign dhit     = w_req && (r_state == IDLE) && (|w_match);
    assign w_hway   = ~w_match[0];
    assign w_vway   = w_flush ? r_scan[0] : r_lru[w_idx];
    assign w_way    = (r_state == IDLE) ? w_hway : w_vway;
    assign dmemload = dhit ? w_word[w_hway] : '0;
    assign w_xfer   = (dREN | dWEN) & ~dwait;
    assign w_last   = &r_cnt;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, memory-side requests and array write controls.
    always_comb begin
        w_next   = r_state;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        flushed  = 1'b0;
        w_wen    = '0;
        w_men    = '0;
        w_wdata  = dmemstore;
        w_mvalid = 1'b1;
        w_mdirty = 1'b0;
        w_mtag   = w_tagr[w_way];
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (dhit) begin
                        if (dmemWEN) begin
                            w_wen[w_way] = 1'b1;
                            w_men[w_way] = 1'b1;
                            w_mdirty     = 1'b1;
                        end
                    end else if (w_valid[w_vway] && w_dirty[w_vway]) begin
                        w_next = WB;
                    end else begin
                        w_next = LD;
                    end
                end else if (halt) begin
                    w_next = FLUSH_SCAN;
                end
            end
            WB, FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = {w_tagr[w_vway], w_aidx, r_cnt, 2'b00};
                dstore = w_word[w_vway];
                if (w_xfer && w_last) begin
                    w_men[w_vway] = 1'b1;
                    if (r_state == WB) begin
                        w_next = LD;
                    end else if (&r_scan) begin
                        w_next = CNT_WR;
                    end else begin
                        w_next = FLUSH_SCAN;
                    end
                end
            end
            LD: begin
                dREN  = 1'b1;
                daddr = {w_tag, w_idx, r_cnt, 2'b00};
                if (w_xfer) begin
                    // Line stays invalid until its final word is in place.
                    w_wen[w_vway] = 1'b1;
                    w_men[w_vway] = 1'b1;
                    w_wdata       = dload;
                    w_mvalid      = w_last;
                    w_mtag        = w_tag;
                    if (w_last) begin
                        w_next = IDLE;
                    end
                end
            end
            FLUSH_SCAN: begin
                if (w_valid[w_vway] && w_dirty[w_vway]) begin
                    w_next = FLUSH_WB;
                end else if (&r_scan) begin
                    w_next = CNT_WR;
                end
            end
            CNT_WR: begin
                dWEN   = 1'b1;
                daddr  = CNT_ADDR;
                dstore = r_hit_cnt - r_miss_cnt;
                if (!dwait) begin
                    w_next = HALT;
                end
            end
            HALT: begin
                flushed = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Word/scan counters, replacement bits and hit/miss statistics.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt      <= '0;
            r_scan     <= '0;
            r_lru      <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_xfer && (r_state != CNT_WR)) begin
                r_cnt <= r_cnt + BW'(1);
            end
            if (w_flush && (w_next == FLUSH_SCAN)) begin
                r_scan <= r_scan + SW'(1);
            end
            if (dhit) begin
                r_lru[w_idx] <= ~w_hway;
                r_hit_cnt    <= r_hit_cnt + 32'd1;
            end
            if ((r_state == LD) && w_xfer && w_last) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_param.sv
// Self-checking bench for dcache_param: default geometry plus a 16-set, 4-word-block instance.
module tb_dcache_param;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic        dwait = 1'b0;
    logic [31:0] dmemload, daddr, dstore;
    logic [31:0] dload = '0;

    logic        b_REN = 1'b0;
    logic [31:0] b_addr = '0;
    logic        b_dhit, b_flushed, b_dREN, b_dWEN;
    logic [31:0] b_load, b_daddr, b_dstore;
    logic [31:0] b_dload = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_wr = 0, n_rd = 0, n_rd2 = 0;
    int hits_m = 0, miss_m = 0;
    logic stall_en = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd[$], exp_rd2[$], exp_data[$], exp_data2[$];
    logic [63:0] exp_wr[$];

    always #5 CLK = ~CLK;

    dcache_param u_dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt), .dhit(dhit),
        .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
    );

    dcache_param #(.NSETS(16), .BLKWORDS(4)) u_dut16 (
        .CLK(CLK), .nRST(nRST), .dmemREN(b_REN), .dmemWEN(1'b0),
        .dmemaddr(b_addr), .dmemstore(32'h0), .halt(1'b0), .dhit(b_dhit),
        .dmemload(b_load), .flushed(b_flushed), .dREN(b_dREN), .dWEN(b_dWEN),
        .daddr(b_daddr), .dstore(b_dstore), .dload(b_dload), .dwait(1'b0)
    );

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_val(a);
    endfunction

    // Backing memory commit.
    always @(posedge CLK) begin
        if (nRST && dWEN && !dwait) mem[daddr] = dstore;
    end

    // Optional random memory stalls.
    always @(posedge CLK) begin
        dwait <= stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    end

    // Read data presented for the addresses currently requested.
    always @(negedge CLK) begin
        dload   = mem_rd(daddr);
        b_dload = init_val(b_daddr);
    end

    // Scoreboard: pop expected memory traffic and hit data as the DUTs produce them.
    always begin : mon
        logic [63:0] ew;
        logic [31:0] ea;
        @(negedge CLK);
        #3;
        if (nRST === 1'b1) begin
            if (dWEN && !dwait) begin
                n_wr++;
                n_checks++;
                if (exp_wr.size() == 0) begin
                    $display("FAIL mem_write: unexpected addr=%h data=%h", daddr, dstore);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({daddr, dstore} !== ew)
                        $display("FAIL mem_write: got addr=%h data=%h, want addr=%h data=%h",
                                 daddr, dstore, ew[63:32], ew[31:0]);
                    else n_pass++;
                end
            end
            if (dREN && !dwait) begin
                n_rd++;
                n_checks++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL mem_read: unexpected addr=%h", daddr);
                end else begin
                    ea = exp_rd.pop_front();
                    if (daddr !== ea) $display("FAIL mem_read: got addr=%h, want %h", daddr, ea);
                    else n_pass++;
                end
            end
            if (dhit && dmemREN && !dmemWEN) begin
                n_checks++;
                if (exp_data.size() == 0) begin
                    $display("FAIL load_data: unexpected hit data=%h", dmemload);
                end else begin
                    ea = exp_data.pop_front();
                    if (dmemload !== ea) $display("FAIL load_data: got %h, want %h", dmemload, ea);
                    else n_pass++;
                end
            end
            if (b_dREN && !b_dWEN) begin
                n_rd2++;
                n_checks++;
                if (exp_rd2.size() == 0) begin
                    $display("FAIL mem_read16: unexpected addr=%h", b_daddr);
                end else begin
                    ea = exp_rd2.pop_front();
                    if (b_daddr !== ea) $display("FAIL mem_read16: got addr=%h, want %h", b_daddr, ea);
                    else n_pass++;
                end
            end
            if (b_dhit && b_REN) begin
                n_checks++;
                if (exp_data2.size() == 0) begin
                    $display("FAIL load_data16: unexpected hit data=%h", b_load);
                end else begin
                    ea = exp_data2.pop_front();
                    if (b_load !== ea) $display("FAIL load_data16: got %h, want %h", b_load, ea);
                    else n_pass++;
                end
            end
        end
    end

    // Drive one request on the default instance; returns cycles waited before dhit.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, output int n);
        n = 0;
        dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = d;
        #1;
        while (dhit !== 1'b1 && n < 300) begin
            @(negedge CLK); #1; n++;
        end
        hits_m++;
        @(negedge CLK);
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    // Drive one read on the 16-set instance.
    task automatic access16(input logic [31:0] a, output int n);
        n = 0;
        b_REN = 1'b1; b_addr = a;
        #1;
        while (b_dhit !== 1'b1 && n < 300) begin
            @(negedge CLK); #1; n++;
        end
        @(negedge CLK);
        b_REN = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h100; b_REN = 1'b1;
        #1;
        n_checks++;
        if ({dhit, flushed, dREN, dWEN, b_dhit, b_dREN} !== 6'b0)
            $display("FAIL reset_ctrl: got %b, want 000000", {dhit, flushed, dREN, dWEN, b_dhit, b_dREN});
        else n_pass++;
        n_checks++;
        if ({daddr, dstore, dmemload} !== 96'h0)
            $display("FAIL reset_data: got %h %h %h, want zeros", daddr, dstore, dmemload);
        else n_pass++;
        @(negedge CLK);
        dmemREN = 1'b0; b_REN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_read_miss();
        int n;
        int r0 = n_rd;
        exp_rd.push_back(32'h100); exp_rd.push_back(32'h104);
        exp_data.push_back(init_val(32'h100));
        access(1'b0, 32'h100, 32'h0, n);
        miss_m++;
        n_checks++;
        if (n != 3) $display("FAIL read_miss_latency: got %0d, want 3", n); else n_pass++;
        n_checks++;
        if (n_rd - r0 != 2) $display("FAIL read_miss_words: got %0d, want 2", n_rd - r0); else n_pass++;
    endtask

    task automatic test_write_hit();
        int n;
        int w0 = n_wr;
        int r0 = n_rd;
        access(1'b1, 32'h100, 32'hDEAD_BEEF, n);
        n_checks++;
        if (n != 0) $display("FAIL write_hit_latency: got %0d, want 0", n); else n_pass++;
        exp_data.push_back(32'hDEAD_BEEF);
        access(1'b0, 32'h100, 32'h0, n);
        n_checks++;
        if (n != 0) $display("FAIL read_after_write_latency: got %0d, want 0", n); else n_pass++;
        n_checks++;
        if ((n_wr != w0) || (n_rd != r0))
            $display("FAIL hit_traffic: got %0d transfers, want 0", (n_wr - w0) + (n_rd - r0));
        else n_pass++;
    endtask

    task automatic test_evict();
        int n;
        exp_rd.push_back(32'h200); exp_rd.push_back(32'h204);
        exp_data.push_back(init_val(32'h200));
        access(1'b0, 32'h200, 32'h0, n);
        miss_m++;
        n_checks++;
        if (n != 3) $display("FAIL miss_0x200_latency: got %0d, want 3", n); else n_pass++;
        exp_wr.push_back({32'h100, 32'hDEAD_BEEF});
        exp_wr.push_back({32'h104, init_val(32'h104)});
        exp_rd.push_back(32'h300); exp_rd.push_back(32'h304);
        exp_data.push_back(init_val(32'h300));
        access(1'b0, 32'h300, 32'h0, n);
        miss_m++;
        n_checks++;
        if (n != 5) $display("FAIL wb_then_ld_latency: got %0d, want 5", n); else n_pass++;
        exp_rd.push_back(32'h100); exp_rd.push_back(32'h104);
        exp_data.push_back(32'hDEAD_BEEF);
        access(1'b0, 32'h100, 32'h0, n);
        miss_m++;
        n_checks++;
        if (n != 3) $display("FAIL refetch_written_back: got %0d, want 3", n); else n_pass++;
        n_checks++;
        if (exp_wr.size() + exp_rd.size() + exp_data.size() != 0)
            $display("FAIL evict_drain: got %0d pending, want 0", exp_wr.size() + exp_rd.size() + exp_data.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_ld();
        int n;
        exp_rd.push_back(32'h400); exp_rd.push_back(32'h404);
        dmemREN = 1'b1; dmemaddr = 32'h400;
        @(negedge CLK);
        @(negedge CLK);
        #4;
        nRST = 1'b0; dmemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        hits_m = 0; miss_m = 0;
        @(negedge CLK);
        n_checks++;
        if (exp_rd.size() != 0) $display("FAIL aborted_ld_reads: got %0d pending, want 0", exp_rd.size());
        else n_pass++;
        exp_rd.push_back(32'h400); exp_rd.push_back(32'h404);
        exp_data.push_back(init_val(32'h400));
        access(1'b0, 32'h400, 32'h0, n);
        miss_m++;
        n_checks++;
        if (n != 3) $display("FAIL refetch_after_reset: got %0d, want 3", n); else n_pass++;
    endtask

    task automatic test_flush();
        int n;
        int w0;
        int cyc;
        int held_bad;
        exp_rd.push_back(32'h100); exp_rd.push_back(32'h104);
        access(1'b1, 32'h100, 32'h1111_1111, n); miss_m++;
        exp_rd.push_back(32'h108); exp_rd.push_back(32'h10C);
        access(1'b1, 32'h108, 32'h2222_2222, n); miss_m++;
        exp_rd.push_back(32'h010); exp_rd.push_back(32'h014);
        access(1'b1, 32'h010, 32'h3333_3333, n); miss_m++;
        n_checks++;
        if (n != 3) $display("FAIL write_miss_latency: got %0d, want 3", n); else n_pass++;
        exp_data.push_back(init_val(32'h400));
        access(1'b0, 32'h400, 32'h0, n);
        exp_data.push_back(init_val(32'h400));
        access(1'b0, 32'h400, 32'h0, n);
        exp_wr.push_back({32'h100, 32'h1111_1111});
        exp_wr.push_back({32'h104, init_val(32'h104)});
        exp_wr.push_back({32'h108, 32'h2222_2222});
        exp_wr.push_back({32'h10C, init_val(32'h10C)});
        exp_wr.push_back({32'h010, 32'h3333_3333});
        exp_wr.push_back({32'h014, init_val(32'h014)});
        exp_wr.push_back({32'h0000_3100, 32'(hits_m - miss_m)});
        w0 = n_wr;
        stall_en = 1'b1;
        halt = 1'b1;
        cyc = 0;
        while (flushed !== 1'b1 && cyc < 1000) begin
            @(negedge CLK); #1; cyc++;
        end
        n_checks++;
        if (flushed !== 1'b1) $display("FAIL flush_done: flushed=%b after %0d cycles, want 1", flushed, cyc);
        else n_pass++;
        n_checks++;
        if (n_wr - w0 != 7) $display("FAIL flush_write_count: got %0d, want 7", n_wr - w0); else n_pass++;
        held_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); #1;
            if (flushed !== 1'b1 || dREN !== 1'b0 || dWEN !== 1'b0) held_bad++;
        end
        n_checks++;
        if (held_bad != 0) $display("FAIL halt_hold: got %0d bad cycles, want 0", held_bad); else n_pass++;
        n_checks++;
        if (exp_wr.size() != 0) $display("FAIL flush_drain: got %0d pending, want 0", exp_wr.size());
        else n_pass++;
        stall_en = 1'b0;
    endtask

    task automatic test_params16();
        int n;
        for (int k = 0; k < 4; k++) exp_rd2.push_back(32'h3F0 + 32'(4 * k));
        exp_data2.push_back(init_val(32'h3F0));
        access16(32'h3F0, n);
        n_checks++;
        if (n != 5) $display("FAIL p16_miss_3f0: got %0d, want 5", n); else n_pass++;
        exp_data2.push_back(init_val(32'h3F8));
        access16(32'h3F8, n);
        n_checks++;
        if (n != 0) $display("FAIL p16_hit_3f8: got %0d, want 0", n); else n_pass++;
        for (int k = 0; k < 4; k++) exp_rd2.push_back(32'(4 * k));
        exp_data2.push_back(init_val(32'h00C));
        access16(32'h00C, n);
        n_checks++;
        if (n != 5) $display("FAIL p16_miss_0: got %0d, want 5", n); else n_pass++;
        for (int k = 0; k < 4; k++) exp_rd2.push_back(32'h1F0 + 32'(4 * k));
        exp_data2.push_back(init_val(32'h1F0));
        access16(32'h1F0, n);
        n_checks++;
        if (n != 5) $display("FAIL p16_miss_1f0: got %0d, want 5", n); else n_pass++;
        exp_data2.push_back(init_val(32'h3F4));
        access16(32'h3F4, n);
        n_checks++;
        if (n != 0) $display("FAIL p16_tag_split: got %0d, want 0", n); else n_pass++;
        n_checks++;
        if (exp_rd2.size() + exp_data2.size() != 0)
            $display("FAIL p16_drain: got %0d pending, want 0", exp_rd2.size() + exp_data2.size());
        else n_pass++;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_params16();
        test_read_miss();
        test_write_hit();
        test_evict();
        test_reset_mid_ld();
        test_flush();
        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
